// File: rtl/synth_pkg.sv
// ============================================================================
// Package : synth_pkg
// Shared opcodes, error code and FSM encoding for the voice allocator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package synth_pkg;

  localparam logic [2:0] OP_KEY_ON     = 3'd0;
  localparam logic [2:0] OP_KEY_OFF    = 3'd1;
  localparam logic [2:0] OP_EFFECT_ON  = 3'd2;
  localparam logic [2:0] OP_EFFECT_OFF = 3'd3;
  localparam logic [2:0] OP_ALL_OFF    = 3'd4;
  localparam logic [2:0] OP_QUERY      = 3'd5;

  localparam logic [31:0] RESULT_ERR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/synth_ci_voice_alloc.sv
// ============================================================================
// Module  : synth_ci_voice_alloc
// Nios II multi-cycle custom instruction: polyphonic voice allocator plus
// effect enable bitmap. Define SYNTH_VOICE_STEAL_EN to enable voice stealing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module synth_ci_voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_KEYS    = 88,
  parameter int NUM_VOICES  = 8,
  parameter int NUM_EFFECTS = 18
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clk_en,
  input  logic                                  start,
  input  logic [2:0]                            opcode,
  input  logic [31:0]                           data,
  output logic                                  done,
  output logic [31:0]                           result,
  output logic                                  busy,
  output logic [NUM_VOICES*$clog2(NUM_KEYS)-1:0] voice_key,
  output logic [NUM_VOICES-1:0]                 voice_gate,
  output logic [NUM_EFFECTS-1:0]                effects_ctrl
);

  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam int PTR_W = $clog2(NUM_VOICES);
  localparam int EFF_W = $clog2(NUM_EFFECTS);

  state_t                 r_state;
  logic                   r_is_on;
  logic [KEY_W-1:0]       r_key;
  logic [PTR_W-1:0]       r_idx;
  logic                   r_hit;
  logic [PTR_W-1:0]       r_hit_idx;
  logic                   r_free;
  logic [PTR_W-1:0]       r_free_idx;
  logic [KEY_W-1:0]       r_vkey [NUM_VOICES];
  logic [NUM_VOICES-1:0]  r_gate;
  logic [NUM_EFFECTS-1:0] r_fx;
  logic                   r_done;
  logic                   r_busy;
  logic [31:0]            r_result;
`ifdef SYNTH_VOICE_STEAL_EN
  logic [PTR_W-1:0]       r_steal;
`endif

  logic             w_match;
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;
  logic             w_free;
  logic [PTR_W-1:0] w_free_idx;
  logic             w_last;
  logic             w_key_cmd;
  logic             w_fx_cmd;
  logic             w_err;

  // Running "first match" / "first free" search, folding in the voice at r_idx
  assign w_match    = r_gate[r_idx] && (r_vkey[r_idx] == r_key);
  assign w_hit      = r_hit | w_match;
  assign w_hit_idx  = r_hit ? r_hit_idx : r_idx;
  assign w_free     = r_free | ~r_gate[r_idx];
  assign w_free_idx = r_free ? r_free_idx : r_idx;
  assign w_last     = (r_idx == PTR_W'(NUM_VOICES - 1));

  assign w_key_cmd = (opcode == OP_KEY_ON) || (opcode == OP_KEY_OFF);
  assign w_fx_cmd  = (opcode == OP_EFFECT_ON) || (opcode == OP_EFFECT_OFF);
  assign w_err     = (w_key_cmd && (data >= 32'(NUM_KEYS)))
                  || (w_fx_cmd && (data >= 32'(NUM_EFFECTS)))
                  || (opcode > OP_QUERY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_is_on    <= 1'b0;
      r_key      <= '0;
      r_idx      <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_free     <= 1'b0;
      r_free_idx <= '0;
      for (int v = 0; v < NUM_VOICES; v++) r_vkey[v] <= '0;
      r_gate     <= '0;
      r_fx       <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_result   <= '0;
`ifdef SYNTH_VOICE_STEAL_EN
      r_steal    <= '0;
`endif
    end else if (clk_en) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_err) begin
              r_result <= RESULT_ERR;
              r_done   <= 1'b1;
              r_state  <= COMMIT;
            end else if (w_key_cmd) begin
              r_is_on <= (opcode == OP_KEY_ON);
              r_key   <= data[KEY_W-1:0];
              r_idx   <= '0;
              r_hit   <= 1'b0;
              r_free  <= 1'b0;
              r_state <= SCAN;
            end else begin
              r_done   <= 1'b1;
              r_state  <= COMMIT;
              r_result <= '0;
              case (opcode)
                OP_EFFECT_ON:  r_fx[data[EFF_W-1:0]] <= 1'b1;
                OP_EFFECT_OFF: r_fx[data[EFF_W-1:0]] <= 1'b0;
                OP_ALL_OFF: begin
                  r_gate <= '0;
                  r_fx   <= '0;
                end
                default:       r_result <= 32'(r_gate);
              endcase
            end
          end
        end

        SCAN: begin
          r_hit      <= w_hit;
          r_hit_idx  <= w_hit_idx;
          r_free     <= w_free;
          r_free_idx <= w_free_idx;
          r_idx      <= r_idx + 1'b1;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= COMMIT;
            if (r_is_on) begin
              if (w_hit) begin
                r_result <= 32'(w_hit_idx);
              end else if (w_free) begin
                r_vkey[w_free_idx] <= r_key;
                r_gate[w_free_idx] <= 1'b1;
                r_result           <= 32'(w_free_idx);
              end else begin
`ifdef SYNTH_VOICE_STEAL_EN
                r_vkey[r_steal] <= r_key;
                r_result        <= 32'(r_steal);
                r_steal         <= (r_steal == PTR_W'(NUM_VOICES - 1)) ? '0 : r_steal + 1'b1;
`else
                r_result <= RESULT_ERR;
`endif
              end
            end else if (w_hit) begin
              r_gate[w_hit_idx] <= 1'b0;
              r_result          <= 32'(w_hit_idx);
            end else begin
              r_result <= RESULT_ERR;
            end
          end
        end

        COMMIT: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
    assign voice_key[v*KEY_W +: KEY_W] = r_vkey[v];
  end

  assign done         = r_done;
  assign result       = r_result;
  assign busy         = r_busy;
  assign voice_gate   = r_gate;
  assign effects_ctrl = r_fx;

endmodule

`default_nettype wire

// File: tb/tb_synth_ci_voice_alloc.sv
// ============================================================================
// Module  : tb_synth_ci_voice_alloc
// Directed self-checking bench for synth_ci_voice_alloc with NUM_VOICES=4.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_synth_ci_voice_alloc;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] data = 32'd0;
  logic        done;
  logic [31:0] result;
  logic        busy;
  logic [27:0] voice_key;
  logic [3:0]  voice_gate;
  logic [17:0] effects_ctrl;

  int checks = 0;
  int errors = 0;
  time t0;
  int lat;
  logic [27:0] vk_full;
  logic [31:0] r_steal0;
  logic [31:0] r_steal1;
  logic        saw_done;

  synth_ci_voice_alloc #(
    .NUM_KEYS(88),
    .NUM_VOICES(4),
    .NUM_EFFECTS(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .start(start),
    .opcode(opcode),
    .data(data),
    .done(done),
    .result(result),
    .busy(busy),
    .voice_key(voice_key),
    .voice_gate(voice_gate),
    .effects_ctrl(effects_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    data   = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = $time;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    lat = int'(($time - t0) / 10) + 1;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    @(posedge clk);
    #1;
    chk({tag, " done width"}, 32'(done), 32'd0);
  endtask

  task automatic cmd(input string tag, input logic [2:0] op, input logic [31:0] d,
                     input logic [31:0] exp_res, input int exp_lat);
    issue(op, d);
    wait_done(tag, exp_res, exp_lat);
  endtask

  initial begin
`ifdef SYNTH_VOICE_STEAL_EN
    r_steal0 = 32'd0;
    r_steal1 = 32'd1;
    vk_full  = {7'd44, 7'd42, 7'd51, 7'd50};
`else
    r_steal0 = RESULT_ERR;
    r_steal1 = RESULT_ERR;
    vk_full  = {7'd44, 7'd42, 7'd43, 7'd40};
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset voice_key", 32'(voice_key), 32'd0);
    chk("reset gate", 32'(voice_gate), 32'd0);
    chk("reset effects", 32'(effects_ctrl), 32'd0);

    issue(OP_KEY_ON, 32'd40);
    chk("busy in scan", 32'(busy), 32'd1);
    wait_done("on40", 32'd0, 5);
    chk("busy after done", 32'(busy), 32'd0);
    cmd("on41", OP_KEY_ON, 32'd41, 32'd1, 5);
    cmd("on42", OP_KEY_ON, 32'd42, 32'd2, 5);
    chk("gate 0111", 32'(voice_gate), 32'h7);
    chk("voice_key0", 32'(voice_key[6:0]), 32'd40);
    chk("voice_key all", 32'(voice_key), 32'({7'd0, 7'd42, 7'd41, 7'd40}));

    cmd("retrig41", OP_KEY_ON, 32'd41, 32'd1, 5);
    chk("retrig gate", 32'(voice_gate), 32'h7);
    cmd("off41", OP_KEY_OFF, 32'd41, 32'd1, 5);
    chk("off gate", 32'(voice_gate), 32'h5);
    chk("off key kept", 32'(voice_key[13:7]), 32'd41);
    cmd("off41 again", OP_KEY_OFF, 32'd41, RESULT_ERR, 5);

    cmd("on43", OP_KEY_ON, 32'd43, 32'd1, 5);
    cmd("on44", OP_KEY_ON, 32'd44, 32'd3, 5);
    chk("full gate", 32'(voice_gate), 32'hF);
    cmd("full on50", OP_KEY_ON, 32'd50, r_steal0, 5);
    cmd("full on51", OP_KEY_ON, 32'd51, r_steal1, 5);
    chk("full voice_key", 32'(voice_key), 32'(vk_full));
    chk("full gate kept", 32'(voice_gate), 32'hF);

    cmd("key 88", OP_KEY_ON, 32'd88, RESULT_ERR, 1);
    chk("key 88 vk", 32'(voice_key), 32'(vk_full));
    chk("key 88 gate", 32'(voice_gate), 32'hF);
    cmd("fx 18", OP_EFFECT_ON, 32'd18, RESULT_ERR, 1);
    chk("fx 18 effects", 32'(effects_ctrl), 32'd0);
    cmd("fx 17", OP_EFFECT_ON, 32'd17, 32'd0, 1);
    chk("fx 17 effects", 32'(effects_ctrl), 32'h20000);
    cmd("fx 3", OP_EFFECT_ON, 32'd3, 32'd0, 1);
    chk("fx 3 effects", 32'(effects_ctrl), 32'h20008);
    cmd("fx off 3", OP_EFFECT_OFF, 32'd3, 32'd0, 1);
    chk("fx off 3 effects", 32'(effects_ctrl), 32'h20000);
    cmd("query full", OP_QUERY, 32'd0, 32'hF, 1);
    cmd("reserved op", 3'd6, 32'd0, RESULT_ERR, 1);
    chk("reserved effects", 32'(effects_ctrl), 32'h20000);
    cmd("all off", OP_ALL_OFF, 32'd0, 32'd0, 1);
    chk("all off gate", 32'(voice_gate), 32'd0);
    chk("all off effects", 32'(effects_ctrl), 32'd0);
    chk("all off vk kept", 32'(voice_key), 32'(vk_full));
    cmd("query empty", OP_QUERY, 32'd0, 32'd0, 1);

    // Second start during SCAN, then clk_en dropped for three edges
    issue(OP_KEY_ON, 32'd60);
    @(negedge clk);
    start  = 1'b1;
    opcode = OP_EFFECT_ON;
    data   = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("frozen busy", 32'(busy), 32'd1);
    chk("frozen done", 32'(done), 32'd0);
    @(negedge clk);
    clk_en = 1'b1;
    wait_done("stall on60", 32'd0, 8);
    chk("ignored start fx", 32'(effects_ctrl), 32'd0);
    chk("stall gate", 32'(voice_gate), 32'h1);
    chk("stall key0", 32'(voice_key[6:0]), 32'd60);

    // Reset asserted in the second SCAN cycle
    issue(OP_KEY_ON, 32'd70);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset vk", 32'(voice_key), 32'd0);
    chk("mid reset gate", 32'(voice_gate), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("mid reset no done", 32'(saw_done), 32'd0);
    chk("mid reset result", result, 32'd0);
    cmd("after reset on10", OP_KEY_ON, 32'd10, 32'd0, 5);
    chk("after reset gate", 32'(voice_gate), 32'h1);
    chk("after reset vk", 32'(voice_key), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
